// File: rtl/jtag_tap_n.sv
// ---------------------------------------------------------------------------
// jtag_tap_n
//
// IEEE 1149.1 style test access port for the ripple-adder DFT flow. It holds
// the 16-state TAP controller, an IR_W-bit instruction register, a 1-bit
// bypass register, an optional 32-bit IDCODE register and a BSR_LEN-cell
// boundary-scan register with capture, shift and update stages.
//
// Configuration macro:
//   JTAG_IDCODE_EN  defined   : IDCODE register built, default instruction
//                               after TLR/Reset is IDCODE (2).
//                   undefined : no IDCODE register, opcode 2 decodes as
//                               bypass, default instruction is BYPASS (all
//                               ones), IDCODE_VAL is not used for capture.
//
// Parameters:
//   IR_W        instruction register width (>= 2)
//   BSR_LEN     boundary-scan register length (>= 1)
//   IDCODE_VAL  IDCODE capture value (bit 0 must be 1)
//
// Ports:
//   TCK        in   only clock; TMS/TDI sampled on rising edge
//   Reset      in   asynchronous, active-high
//   TMS        in   test mode select
//   TDI        in   test data in
//   TDO        out  test data out, re-timed on falling TCK
//   TDO_en     out  high only in Shift-DR / Shift-IR (falling TCK)
//   bsr_pi     in   parallel capture inputs from system/core pins
//   bsr_po     out  parallel outputs to the pins
//   Mode       out  high while the active instruction is EXTEST
//   tap_state  out  current TAP state code
//   ir_q       out  active (updated) instruction
// ---------------------------------------------------------------------------
module jtag_tap_n #(
  parameter int          IR_W       = 4,
  parameter int          BSR_LEN    = 66,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5B
) (
  input  logic               TCK,
  input  logic               Reset,
  input  logic               TMS,
  input  logic               TDI,
  output logic               TDO,
  output logic               TDO_en,
  input  logic [BSR_LEN-1:0] bsr_pi,
  output logic [BSR_LEN-1:0] bsr_po,
  output logic               Mode,
  output logic [3:0]         tap_state,
  output logic [IR_W-1:0]    ir_q
);

  // TAP state codes are the architected values reported on tap_state.
  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  localparam logic [IR_W-1:0] OP_EXTEST  = {IR_W{1'b0}};
  localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(32'd1);
  localparam logic [IR_W-1:0] OP_BYPASS  = {IR_W{1'b1}};
  // Capture pattern {0..0,01} lets a board tester verify IR chain integrity.
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(32'd1);

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(32'd2);
  localparam logic [IR_W-1:0] DEFAULT_IR = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] DEFAULT_IR = OP_BYPASS;
`endif

  // Elaboration-time parameter sanity checks.
  if (IR_W < 2) begin : g_ir_w_check
    $error("jtag_tap_n: IR_W must be at least 2");
  end
  if (BSR_LEN < 1) begin : g_bsr_len_check
    $error("jtag_tap_n: BSR_LEN must be at least 1");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb_check
    $error("jtag_tap_n: IDCODE_VAL bit 0 must be 1");
  end

  // -------------------------------------------------------------------------
  // Signals
  // -------------------------------------------------------------------------
  tap_state_e         state_r;
  tap_state_e         state_nxt_s;

  logic [IR_W-1:0]    ir_sh_r;
  logic [IR_W-1:0]    ir_q_r;
  logic [IR_W-1:0]    ir_nxt_s;
  logic               mode_r;

  logic               byp_r;
  logic [BSR_LEN-1:0] bsr_sh_r;
  logic [BSR_LEN-1:0] bsr_shift_s;
  logic [BSR_LEN-1:0] bsr_upd_r;
`ifdef JTAG_IDCODE_EN
  logic [31:0]        id_sh_r;
`endif

  logic               sel_bsr_s;
  logic               sel_id_s;
  logic               sel_byp_s;
  logic               dr_lsb_s;
  logic               tdo_nxt_s;
  logic               tdo_en_nxt_s;
  logic               tdo_r;
  logic               tdo_en_r;

  // -------------------------------------------------------------------------
  // TAP controller
  // -------------------------------------------------------------------------

  // TAP state register; Reset forces Test-Logic-Reset immediately.
  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      state_r <= TLR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // TAP next-state decode from TMS.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      TLR:     state_nxt_s = TMS ? TLR    : RTI;
      RTI:     state_nxt_s = TMS ? SEL_DR : RTI;
      SEL_DR:  state_nxt_s = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt_s = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_nxt_s = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt_s = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_nxt_s = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_nxt_s = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt_s = TMS ? SEL_DR : RTI;
      SEL_IR:  state_nxt_s = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_nxt_s = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_nxt_s = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt_s = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_nxt_s = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_nxt_s = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt_s = TMS ? SEL_DR : RTI;
      default: state_nxt_s = TLR;
    endcase
  end

  // -------------------------------------------------------------------------
  // Instruction decode: EXTEST/SAMPLE -> BSR, IDCODE -> IDCODE, else bypass.
  // -------------------------------------------------------------------------

  // Data register selection from the active instruction.
  always_comb begin
    sel_bsr_s = (ir_q_r == OP_EXTEST) || (ir_q_r == OP_SAMPLE);
`ifdef JTAG_IDCODE_EN
    sel_id_s  = (ir_q_r == OP_IDCODE);
`else
    sel_id_s  = 1'b0;
`endif
    sel_byp_s = !sel_bsr_s && !sel_id_s;
  end

  // -------------------------------------------------------------------------
  // Shift stages (rising TCK)
  // -------------------------------------------------------------------------

  // Instruction shift stage: capture fixed pattern, shift TDI into MSB.
  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      ir_sh_r <= {IR_W{1'b0}};
    end else if (state_r == CAP_IR) begin
      ir_sh_r <= IR_CAPTURE;
    end else if (state_r == SH_IR) begin
      ir_sh_r <= {TDI, ir_sh_r[IR_W-1:1]};
    end else begin
      ir_sh_r <= ir_sh_r;
    end
  end

  // Bypass register: captures 0, then acts as a one-cell delay.
  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      byp_r <= 1'b0;
    end else if (sel_byp_s && (state_r == CAP_DR)) begin
      byp_r <= 1'b0;
    end else if (sel_byp_s && (state_r == SH_DR)) begin
      byp_r <= TDI;
    end else begin
      byp_r <= byp_r;
    end
  end

  // A one-cell BSR has no upper bits to move down, so the shift is just TDI.
  if (BSR_LEN > 1) begin : g_bsr_wide
    assign bsr_shift_s = {TDI, bsr_sh_r[BSR_LEN-1:1]};
  end else begin : g_bsr_one
    assign bsr_shift_s = TDI;
  end

  // Boundary-scan shift stage: capture pins, shift TDI into MSB.
  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      bsr_sh_r <= {BSR_LEN{1'b0}};
    end else if (sel_bsr_s && (state_r == CAP_DR)) begin
      bsr_sh_r <= bsr_pi;
    end else if (sel_bsr_s && (state_r == SH_DR)) begin
      bsr_sh_r <= bsr_shift_s;
    end else begin
      bsr_sh_r <= bsr_sh_r;
    end
  end

`ifdef JTAG_IDCODE_EN
  // IDCODE shift stage: capture the device identity, shift TDI into MSB.
  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      id_sh_r <= 32'h0000_0000;
    end else if (sel_id_s && (state_r == CAP_DR)) begin
      id_sh_r <= IDCODE_VAL;
    end else if (sel_id_s && (state_r == SH_DR)) begin
      id_sh_r <= {TDI, id_sh_r[31:1]};
    end else begin
      id_sh_r <= id_sh_r;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Update stages and TDO retiming (falling TCK)
  // -------------------------------------------------------------------------

  // Next active instruction: default in TLR, shift stage in Update-IR.
  always_comb begin
    ir_nxt_s = ir_q_r;
    if (state_r == TLR) begin
      ir_nxt_s = DEFAULT_IR;
    end else if (state_r == UPD_IR) begin
      ir_nxt_s = ir_sh_r;
    end else begin
      ir_nxt_s = ir_q_r;
    end
  end

  // Active instruction and Mode; changing only on falling TCK keeps the core
  // from ever seeing a partially shifted opcode.
  always_ff @(negedge TCK or posedge Reset) begin
    if (Reset) begin
      ir_q_r <= DEFAULT_IR;
      mode_r <= 1'b0;
    end else begin
      ir_q_r <= ir_nxt_s;
      mode_r <= (ir_nxt_s == OP_EXTEST);
    end
  end

  // BSR update latch: loaded in Update-DR while the BSR is selected.
  always_ff @(negedge TCK or posedge Reset) begin
    if (Reset) begin
      bsr_upd_r <= {BSR_LEN{1'b0}};
    end else if (sel_bsr_s && (state_r == UPD_DR)) begin
      bsr_upd_r <= bsr_sh_r;
    end else begin
      bsr_upd_r <= bsr_upd_r;
    end
  end

  // LSB of the currently selected data register.
  always_comb begin
    dr_lsb_s = byp_r;
    if (sel_bsr_s) begin
      dr_lsb_s = bsr_sh_r[0];
`ifdef JTAG_IDCODE_EN
    end else if (sel_id_s) begin
      dr_lsb_s = id_sh_r[0];
`endif
    end else begin
      dr_lsb_s = byp_r;
    end
  end

  // TDO source and enable: only the two shift states drive data.
  always_comb begin
    tdo_nxt_s    = 1'b0;
    tdo_en_nxt_s = 1'b0;
    case (state_r)
      SH_IR: begin
        tdo_nxt_s    = ir_sh_r[0];
        tdo_en_nxt_s = 1'b1;
      end
      SH_DR: begin
        tdo_nxt_s    = dr_lsb_s;
        tdo_en_nxt_s = 1'b1;
      end
      default: begin
        tdo_nxt_s    = 1'b0;
        tdo_en_nxt_s = 1'b0;
      end
    endcase
  end

  // TDO/TDO_en retimed on falling TCK so the next device samples a stable bit.
  always_ff @(negedge TCK or posedge Reset) begin
    if (Reset) begin
      tdo_r    <= 1'b0;
      tdo_en_r <= 1'b0;
    end else begin
      tdo_r    <= tdo_nxt_s;
      tdo_en_r <= tdo_en_nxt_s;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Pins stay transparent unless EXTEST drives them from the update latch.
  assign bsr_po    = mode_r ? bsr_upd_r : bsr_pi;
  assign Mode      = mode_r;
  assign TDO       = tdo_r;
  assign TDO_en    = tdo_en_r;
  assign tap_state = state_r;
  assign ir_q      = ir_q_r;

endmodule
